// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// Optional build macro DELAY_SLOT_EN selects delay-slot redirects instead of flushing.
package pc_seq_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2,
        S_HALT  = 2'd3
    } seq_state_e;

    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_SEQ,
        SRC_JMP,
        SRC_BR,
        SRC_PEND
    } npc_src_e;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/redirect inputs and fetch-address outputs of the PC sequencer.
// master = pipeline side driving control, slave = the sequencer itself.
interface pc_sequencer_if;
    import pc_seq_pkg::*;

    logic            stall;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            jmp;
    logic [PC_W-1:0] jmp_target;
    logic            halt;
    logic [PC_W-1:0] PC;
    logic [PC_W-1:0] npc;
    logic            if_valid;
    logic            if_flush;

    modport master (
        output stall, br_taken, br_target, jmp, jmp_target, halt,
        input  PC, npc, if_valid, if_flush
    );

    modport slave (
        input  stall, br_taken, br_target, jmp, jmp_target, halt,
        output PC, npc, if_valid, if_flush
    );

endinterface

// File: rtl/pc_next_mux.sv
// Stateless priority select for the next PC: halt > jmp > branch > pending > stall > step.
// With DELAY_SLOT_EN a redirect first steps into the slot; the target comes via pending.
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_STEP = 4
) (
    input  logic            frozen,
    input  logic            halt,
    input  logic            stall,
    input  logic            jmp,
    input  logic            br_taken,
    input  logic            redir_en,
    input  logic            pend_valid,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] jmp_target,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] pend_target,
    output npc_src_e        src,
    output logic [PC_W-1:0] redir_target,
    output logic [PC_W-1:0] npc
);

    logic [PC_W-1:0] pc_seq;

    assign pc_seq = pc + PC_W'(PC_STEP);

    always_comb begin
        src          = SRC_HOLD;
        npc          = pc;
        redir_target = align_pc(jmp ? jmp_target : br_target);

        if (frozen || halt) begin
            src = SRC_HOLD;
        end else if (redir_en && jmp) begin
            src = SRC_JMP;
        end else if (redir_en && br_taken) begin
            src = SRC_BR;
        end else if (pend_valid && !stall) begin
            src = SRC_PEND;
        end else if (!stall) begin
            src = SRC_SEQ;
        end

        case (src)
            SRC_JMP, SRC_BR: begin
`ifdef DELAY_SLOT_EN
                npc = stall ? pc : pc_seq;
`else
                npc = stall ? pc : redir_target;
`endif
            end
            SRC_PEND: npc = pend_target;
            SRC_SEQ:  npc = pc_seq;
            default:  npc = pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: state FSM, deferred-redirect register and PC register.
// DELAY_SLOT_EN: redirects execute one delay slot and never flush.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned PC_STEP   = 4
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            if_valid_q, if_valid_d;
    logic            pend_valid_q, pend_valid_d;
    logic [PC_W-1:0] pend_target_q, pend_target_d;
    logic            if_flush;
    logic            frozen;
    logic            redir_en;
    npc_src_e        src;
    logic [PC_W-1:0] redir_target;
    logic [PC_W-1:0] mux_npc;

    assign frozen = (state_q == S_RESET) || (state_q == S_HALT);

    // In delay-slot mode an outstanding redirect (slot or stalled) blocks new ones.
`ifdef DELAY_SLOT_EN
    assign redir_en = !pend_valid_q;
`else
    assign redir_en = 1'b1;
`endif

    pc_next_mux #(
        .PC_STEP (PC_STEP)
    ) u_mux (
        .frozen       (frozen),
        .halt         (bus.halt),
        .stall        (bus.stall),
        .jmp          (bus.jmp),
        .br_taken     (bus.br_taken),
        .redir_en     (redir_en),
        .pend_valid   (pend_valid_q),
        .pc           (pc_q),
        .jmp_target   (bus.jmp_target),
        .br_target    (bus.br_target),
        .pend_target  (pend_target_q),
        .src          (src),
        .redir_target (redir_target),
        .npc          (mux_npc)
    );

    always_comb begin
        state_d       = state_q;
        if_valid_d    = if_valid_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if_flush      = 1'b0;
        pc_d          = mux_npc;

        case (state_q)
            S_RESET: begin
                state_d    = S_FETCH;
                if_valid_d = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_FETCH, S_STALL: begin
                if (bus.halt) begin
                    state_d      = S_HALT;
                    if_valid_d   = 1'b0;
                    pend_valid_d = 1'b0;
                end else begin
                    state_d = bus.stall ? S_STALL : S_FETCH;
                    case (src)
                        SRC_JMP, SRC_BR: begin
                            pend_target_d = redir_target;
`ifdef DELAY_SLOT_EN
                            pend_valid_d  = 1'b1;
`else
                            pend_valid_d  = bus.stall;
                            if_flush      = !bus.stall;
`endif
                        end
                        SRC_PEND: begin
                            pend_valid_d = 1'b0;
`ifndef DELAY_SLOT_EN
                            if_flush     = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase

        // npc mirrors the register D input, so reset must show up here too.
        if (rst) begin
            pc_d     = RESET_VEC;
            if_flush = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RESET;
            pc_q          <= RESET_VEC;
            if_valid_q    <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign bus.PC       = pc_q;
    assign bus.npc      = pc_d;
    assign bus.if_valid = if_valid_q;
    assign bus.if_flush = if_flush;

endmodule
